// File: rtl/crc_frame_sequencer_pkg.sv
// crc_pkg: shared image defaults, FSM state codes and pipeline tag type for the frame sequencer
package crc_pkg;
    localparam int IMG_W_DEF      = 640;
    localparam int IMG_H_DEF      = 480;
    localparam int ADDR_W_DEF     = 19;
    localparam int PIPE_LAT_DEF   = 5;
    localparam int FIFO_DEPTH_DEF = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;
    typedef struct packed {
        logic vld;
        logic sof;
        logic eol;
        logic eof;
    } pix_tag_t;
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction
endpackage

// File: rtl/crc_frame_sequencer_if.sv
// crc_frame_sequencer_if: tagged corrected-pixel stream with valid/ready handshake
interface crc_frame_sequencer_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_sof;
    logic       out_eol;
    logic       out_eof;
    modport master(output out_valid, out_data, out_sof, out_eol, out_eof, input out_ready);
    modport slave(input out_valid, out_data, out_sof, out_eol, out_eof, output out_ready);
endinterface

// File: rtl/crc_frame_sequencer_out_fifo.sv
// crc_out_fifo: first-word fall-through FIFO with occupancy count and synchronous flush
module crc_out_fifo
    import crc_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 11,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = clog2_min1(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d    = flush ? '0 : do_push ? ((wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1) : wr_q;
        rd_d    = flush ? '0 : do_pop ? ((rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1) : rd_q;
        count_d = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= wdata;
    end

    assign rdata = mem_q[rd_q];
    assign count = count_q;
    assign empty = count_q == '0;
    assign full  = count_q == CW'(DEPTH);
endmodule

// File: rtl/crc_frame_sequencer.sv
// crc_frame_sequencer: issues raster pixel indices under FIFO credit and tags returning corrected pixels
module crc_frame_sequencer
    import crc_pkg::*;
#(
    parameter int IMG_W      = IMG_W_DEF,
    parameter int IMG_H      = IMG_H_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int PIPE_LAT   = PIPE_LAT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_W-1:0]     cnt,
    input  logic [7:0]            pix_data,
    crc_frame_sequencer_if.master out,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf_err
);
    localparam int XW   = clog2_min1(IMG_W);
    localparam int YW   = clog2_min1(IMG_H);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int LW   = $clog2(PIPE_LAT + 1);
    localparam int NPIX = IMG_W * IMG_H;

    logic [1:0]              state_q, state_d;
    logic [ADDR_W-1:0]       cnt_q, cnt_d;
    logic [XW-1:0]           x_q, x_d;
    logic [YW-1:0]           y_q, y_d;
    pix_tag_t [PIPE_LAT-1:0] pipe_q, pipe_d;
    logic                    done_q, done_d, ovf_q, ovf_d;
    logic [LW-1:0]           inflight;
    logic [CW-1:0]           fifo_count;
    logic [10:0]             fifo_rdata;
    logic                    fifo_full, fifo_empty;
    logic                    issue, last, eol, push, pop;
    pix_tag_t                tag_in, tag_out;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < PIPE_LAT; i++) inflight = inflight + LW'(pipe_q[i].vld);
    end

    // Every in-flight pixel holds a FIFO slot, since the datapath cannot be stalled.
    assign issue   = (state_q == RUN) && (int'(fifo_count) + int'(inflight) < FIFO_DEPTH);
    assign last    = cnt_q == ADDR_W'(NPIX - 1);
    assign eol     = x_q == XW'(IMG_W - 1);
    assign tag_in  = issue ? {1'b1, cnt_q == '0, eol, last} : '0;
    assign tag_out = pipe_q[PIPE_LAT-1];
    assign push    = tag_out.vld;
    assign pop     = !fifo_empty && out.out_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q || (push && fifo_full && !pop && !abort);
        pipe_d[0] = tag_in;
        for (int i = 1; i < PIPE_LAT; i++) pipe_d[i] = pipe_q[i-1];
        if (issue) begin
            cnt_d   = last ? '0 : cnt_q + 1'b1;
            x_d     = (last || eol) ? '0 : x_q + 1'b1;
            y_d     = last ? '0 : y_q + YW'(eol);
            state_d = last ? DRAIN : RUN;
        end
        if (state_q == IDLE && start) state_d = RUN;
        if (state_q == DRAIN && pop && out.out_eof && inflight == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            x_d     = '0;
            y_d     = '0;
            pipe_d  = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            pipe_q  <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pipe_q  <= pipe_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    crc_out_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(11)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (abort),
        .push  (push),
        .pop   (pop),
        .wdata ({pix_data, tag_out.sof, tag_out.eol, tag_out.eof}),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out.out_valid = !fifo_empty;
    assign {out.out_data, out.out_sof, out.out_eol, out.out_eof} = fifo_empty ? '0 : fifo_rdata;
    assign cnt     = cnt_q;
    assign busy    = state_q != IDLE;
    assign done    = done_q;
    assign ovf_err = ovf_q;
endmodule

// File: tb/tb_crc_frame_sequencer.sv
// tb_crc_frame_sequencer: directed frames on a 4x2 image checked against an expected pixel-stream queue
module tb_crc_frame_sequencer;
    localparam int W = 4, H = 2, N = W * H, LAT = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, start2 = 1'b0, abort2 = 1'b0;
    logic [18:0] cnt, cnt2;
    logic [7:0]  pix_data, pix2;
    logic        busy, done, ovf_err, busy2, done2, ovf2;
    logic [7:0]  dp [LAT];
    logic [7:0]  dp2 [LAT];
    logic [10:0] exp_q [$];
    logic        done_exp = 1'b0;
    logic        mon_en = 1'b0;
    logic [18:0] prev_cnt = '0;
    int          n_chk = 0, n_fail = 0, steps;

    crc_frame_sequencer_if ifm ();
    crc_frame_sequencer_if ifo ();

    crc_frame_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(19), .PIPE_LAT(LAT), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cnt(cnt), .pix_data(pix_data),
        .out(ifm), .busy(busy), .done(done), .ovf_err(ovf_err));

    crc_frame_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(19), .PIPE_LAT(LAT), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .cnt(cnt2), .pix_data(pix2),
        .out(ifo), .busy(busy2), .done(done2), .ovf_err(ovf2));

    always #5 clk = ~clk;

    // Correction datapath stand-in: f(cnt) = cnt + 0x10 after LAT register stages.
    assign pix_data = dp[LAT-1];
    assign pix2     = dp2[LAT-1];
    always @(posedge clk) begin
        dp[0]  <= cnt[7:0] + 8'h10;
        dp2[0] <= cnt2[7:0] + 8'h10;
        for (int i = 1; i < LAT; i++) begin
            dp[i]  <= dp[i-1];
            dp2[i] <= dp2[i-1];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        for (int i = 0; i < N; i++)
            exp_q.push_back({8'(8'h10 + i), i == 0, (i % W) == W - 1, i == N - 1});
    endtask

    task automatic kick();
        start = 1'b1;
        push_frame();
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        chk(name, done, 1);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            done_exp = 1'b0;
        end else if (mon_en) begin
            chk("done", done, done_exp);
            if (done) chk("busy_at_done", busy, 0);
            chk("ovf_err", ovf_err, 0);
            chk("cnt_step", (cnt == prev_cnt) || (cnt == prev_cnt + 1'b1) || (cnt == '0), 1);
            done_exp = 1'b0;
            if (abort) exp_q.delete();
            else if (ifm.out_valid) begin
                chk("out_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    chk("out_word", {ifm.out_data, ifm.out_sof, ifm.out_eol, ifm.out_eof}, exp_q[0]);
                    if (ifm.out_ready) begin
                        done_exp = exp_q[0][0];
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
        prev_cnt = cnt;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifm.out_ready = 1'b1;
        ifo.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cnt", cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", ifm.out_valid, 0);
        chk("rst_ovf", ovf_err, 0);
        chk("rst_out", {ifm.out_data, ifm.out_sof, ifm.out_eol, ifm.out_eof}, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step();
        // 1: free-running frame
        kick();
        for (int i = 0; i < N; i++) begin
            chk("t1_cnt", cnt, i);
            step();
        end
        chk("t1_cnt_wrap", cnt, 0);
        wait_done("t1_done", 40, steps);
        chk("t1_latency", N + steps, N + LAT + 1);
        // 2: downstream stalled from the start
        step();
        ifm.out_ready = 1'b0;
        kick();
        repeat (20) step();
        chk("t2_cnt_hold", cnt, 0);
        chk("t2_busy", busy, 1);
        chk("t2_valid", ifm.out_valid, 1);
        chk("t2_head", {ifm.out_data, ifm.out_sof}, {8'h10, 1'b1});
        ifm.out_ready = 1'b1;
        step();
        chk("t2_next", {ifm.out_data, ifm.out_sof, ifm.out_eol}, {8'h11, 2'b00});
        wait_done("t2_done", 40, steps);
        chk("t2_drained", exp_q.size(), 0);
        // 3: alternating ready
        step();
        kick();
        ifm.out_ready = 1'b0;
        steps = 0;
        while (!done && steps < 80) begin
            ifm.out_ready = ~ifm.out_ready;
            step();
            steps++;
        end
        chk("t3_done", done, 1);
        chk("t3_drained", exp_q.size(), 0);
        ifm.out_ready = 1'b1;
        // 4: abort mid-run
        step();
        kick();
        steps = 0;
        while (cnt != 3 && steps < 20) begin
            step();
            steps++;
        end
        chk("t4_at3", cnt, 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_valid", ifm.out_valid, 0);
        chk("t4_cnt", cnt, 0);
        repeat (20) step();
        chk("t4_idle", busy, 0);
        kick();
        wait_done("t4_done", 60, steps);
        // 5: start while busy is ignored; start on done runs back-to-back
        step();
        kick();
        repeat (3) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("t5_done_a", 60, steps);
        kick();
        chk("t5_b2b_busy", busy, 1);
        chk("t5_b2b_cnt", cnt, 0);
        wait_done("t5_done_b", 60, steps);
        repeat (20) step();
        chk("t5_one_frame", busy, 0);
        chk("t5_drained", exp_q.size(), 0);
        // 6: asynchronous reset mid-frame
        step();
        kick();
        steps = 0;
        while (cnt != 5 && steps < 20) begin
            step();
            steps++;
        end
        chk("t6_at5", cnt, 5);
        rst_n = 1'b0;
        #1;
        chk("t6_cnt", cnt, 0);
        chk("t6_busy", busy, 0);
        chk("t6_valid", ifm.out_valid, 0);
        chk("t6_out", {ifm.out_data, ifm.out_sof, ifm.out_eol, ifm.out_eof}, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("t6_idle", busy, 0);
        kick();
        wait_done("t6_done", 60, steps);
        chk("end_drained", exp_q.size(), 0);
        // overflow: credit holds a 4-deep FIFO, then issue is overridden to overrun it
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        repeat (20) step();
        chk("ovf_credit_cnt", cnt2, 4);
        chk("ovf_none", ovf2, 0);
        chk("ovf_full_valid", ifo.out_valid, 1);
        force dut2.issue = 1'b1;
        repeat (6) step();
        release dut2.issue;
        repeat (6) step();
        chk("ovf_set", ovf2, 1);
        abort2 = 1'b1;
        step();
        abort2 = 1'b0;
        chk("ovf_abort_busy", busy2, 0);
        chk("ovf_sticky", ovf2, 1);
        rst_n = 1'b0;
        #1;
        chk("ovf_rst", ovf2, 0);
        step();
        rst_n = 1'b1;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
